// File: rtl/spi_frame_ctrl_if.sv
// Byte-stream, framebuffer-write and swap-handshake bundle between the SPI
// receiver/scanner side and the frame command sequencer.
interface spi_frame_ctrl_if #(
  parameter int WIDTH  = 64,
  parameter int HEIGHT = 32
);
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(PIXELS);

  logic [7:0]        rx_byte;
  logic              rx_done;
  logic              rx_first;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [23:0]       fb_data;
  logic [7:0]        brightness;
  logic              swap_req;
  logic              swap_ack;
  logic              busy;
  logic              err;

  // Sequencer side
  modport slave (
    input  rx_byte, rx_done, rx_first, swap_ack,
    output fb_we, fb_addr, fb_data, brightness, swap_req, busy, err
  );

  // Receiver/scanner side
  modport master (
    output rx_byte, rx_done, rx_first, swap_ack,
    input  fb_we, fb_addr, fb_data, brightness, swap_req, busy, err
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Decodes one command per chip-select transaction from the SPI byte stream:
// pixel writes into the back framebuffer, brightness load, buffer swap request.
module spi_frame_ctrl #(
  parameter int         WIDTH        = 64,
  parameter int         HEIGHT       = 32,
  parameter logic [7:0] BRIGHT_RESET = 8'hFF
) (
  input  logic           clk,
  input  logic           reset,
  spi_frame_ctrl_if.slave bus
);
  localparam int PIXELS = WIDTH * HEIGHT;
  localparam int ADDR_W = $clog2(PIXELS);

  localparam logic [7:0] CMD_PIXELS = 8'h01;
  localparam logic [7:0] CMD_SWAP   = 8'h02;
  localparam logic [7:0] CMD_BRIGHT = 8'h03;

  typedef enum logic [3:0] {
    IDLE, ADDR_HI, ADDR_LO, PIX_R, PIX_G, PIX_B, BRIGHT, SWAP_WAIT, DISCARD
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic [7:0]        addr_hi_reg;
  logic [7:0]        red_reg;
  logic [7:0]        green_reg;
  logic              fb_we_reg;
  logic [ADDR_W-1:0] fb_addr_reg;
  logic [23:0]       fb_data_reg;
  logic [7:0]        brightness_reg;
  logic              swap_req_reg;
  logic              err_reg;

  logic [16:0] start_addr;
  assign start_addr = {1'b0, addr_hi_reg, bus.rx_byte};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      addr_hi_reg    <= '0;
      red_reg        <= '0;
      green_reg      <= '0;
      fb_we_reg      <= 1'b0;
      fb_addr_reg    <= '0;
      fb_data_reg    <= '0;
      brightness_reg <= BRIGHT_RESET;
      swap_req_reg   <= 1'b0;
      err_reg        <= 1'b0;
    end else begin
      fb_we_reg <= 1'b0;
      if (state_reg == SWAP_WAIT) begin
        // The scanner owns the bus until it acks; any byte here is lost.
        if (bus.rx_done) err_reg <= 1'b1;
        if (bus.swap_ack) begin
          swap_req_reg <= 1'b0;
          state_reg    <= IDLE;
        end
      end else if (bus.rx_done && bus.rx_first) begin
        case (bus.rx_byte)
          CMD_PIXELS: state_reg <= ADDR_HI;
          CMD_BRIGHT: state_reg <= BRIGHT;
          CMD_SWAP: begin
            swap_req_reg <= 1'b1;
            state_reg    <= SWAP_WAIT;
          end
          default: begin
            err_reg   <= 1'b1;
            state_reg <= DISCARD;
          end
        endcase
      end else if (bus.rx_done) begin
        case (state_reg)
          IDLE: state_reg <= DISCARD;
          ADDR_HI: begin
            addr_hi_reg <= bus.rx_byte;
            state_reg   <= ADDR_LO;
          end
          ADDR_LO: begin
            if (start_addr < 17'(PIXELS)) begin
              ptr_reg   <= start_addr[ADDR_W-1:0];
              state_reg <= PIX_R;
            end else begin
              err_reg   <= 1'b1;
              state_reg <= DISCARD;
            end
          end
          PIX_R: begin
            red_reg   <= bus.rx_byte;
            state_reg <= PIX_G;
          end
          PIX_G: begin
            green_reg <= bus.rx_byte;
            state_reg <= PIX_B;
          end
          PIX_B: begin
            fb_we_reg   <= 1'b1;
            fb_addr_reg <= ptr_reg;
            fb_data_reg <= {red_reg, green_reg, bus.rx_byte};
            ptr_reg     <= (ptr_reg == ADDR_W'(PIXELS - 1)) ? '0 : ptr_reg + 1'b1;
            state_reg   <= PIX_R;
          end
          BRIGHT: begin
            brightness_reg <= bus.rx_byte;
            state_reg      <= DISCARD;
          end
          default: state_reg <= DISCARD;
        endcase
      end
    end
  end

  assign bus.fb_we      = fb_we_reg;
  assign bus.fb_addr    = fb_addr_reg;
  assign bus.fb_data    = fb_data_reg;
  assign bus.brightness = brightness_reg;
  assign bus.swap_req   = swap_req_reg;
  assign bus.err        = err_reg;
  assign bus.busy       = (state_reg != IDLE);
endmodule
